regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port (rd / RegWrite / write data) and shares it between two writeback sources: the single-cycle ALU path and the variable-latency load/store unit (LSU).
- Holds LSU results in a small FIFO while the ALU has priority.
- Keeps a per-register scoreboard of outstanding loads and stalls issue on RAW/WAW hazards or LSU starvation.
- Sits between the issue stage, the writeback sources and regfile.

Parameters:
- DATA_WIDTH, 32, register data width.
- REG_DATA_WIDTH, 5, register address width; 2**REG_DATA_WIDTH registers.
- FIFO_DEPTH, 2, LSU pending-write entries; power of two, at least 2.
- MAX_WAIT, 4, cycles an LSU head entry may wait before issue is throttled.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction presented at issue.
- issue_rs1  in  REG_DATA_WIDTH  source register 1.
- issue_rs2  in  REG_DATA_WIDTH  source register 2.
- issue_rd  in  REG_DATA_WIDTH  destination register.
- issue_is_load  in  1  instruction writes back via LSU.
- issue_stall  out  1  issue must hold; combinational.
- alu_wb_valid  in  1  ALU result this cycle; cannot be back-pressured.
- alu_wb_rd  in  REG_DATA_WIDTH  ALU destination.
- alu_wb_data  in  DATA_WIDTH  ALU result.
- lsu_wb_valid  in  1  LSU result offered.
- lsu_wb_rd  in  REG_DATA_WIDTH  LSU destination.
- lsu_wb_data  in  DATA_WIDTH  load data.
- lsu_wb_ready  out  1  FIFO not full.
- RegWrite  out  1  regfile write enable, registered.
- rd  out  REG_DATA_WIDTH  regfile write address, registered.
- ALUout  out  DATA_WIDTH  regfile write data, registered.
- busy_vec  out  2**REG_DATA_WIDTH  scoreboard bits, registered.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: RegWrite=0, rd=0, ALUout=0, busy_vec=0, FIFO empty, age counter 0, lsu_wb_ready=1.
  - Reset mid-operation discards queued LSU writes and all busy bits.
- Scoreboard:
  - Issue is accepted when issue_valid && !issue_stall.
  - On an accepted issue with issue_is_load=1 and issue_rd!=0, set busy[issue_rd].
  - busy[0] is never set.
- Hazard stall:
  - issue_stall = issue_valid && (busy[rs1] || busy[rs2] || busy[rd] || starve).
  - rs/rd of x0 never stall; busy[0] is always 0.
- LSU accept:
  - Accept when lsu_wb_valid && lsu_wb_ready; push {rd, data} at the tail.
  - lsu_wb_ready = (count != FIFO_DEPTH), from registered count.
  - Push and pop in the same cycle is legal and leaves count unchanged.
- Write-port selection, each cycle, registered into RegWrite/rd/ALUout:
  - If alu_wb_valid: load ALU result; RegWrite = (alu_wb_rd != 0); FIFO not popped.
  - Else if FIFO non-empty: pop head; RegWrite = (head rd != 0).
  - Else RegWrite=0; rd/ALUout hold their previous values.
- Latency:
  - ALU: 1 cycle from alu_wb_valid to RegWrite; the regfile commits at the following edge.
  - LSU minimum: accept at edge E0, output register loaded at E1, regfile commit at E2.
  - No bypass of the FIFO.
- Busy clear:
  - busy[rd] clears at the edge ending a cycle in which RegWrite=1 and the output came from the FIFO.
  - The bit stays visible during the commit cycle, so issue never reads a stale value.
  - Set and clear of the same bit in one cycle is unreachable because of the WAW stall; if it occurs, set wins.
- Starvation:
  - age increments each cycle the FIFO is non-empty and the head is not popped.
  - age resets to 0 on a pop or when the FIFO is empty; it saturates at MAX_WAIT.
  - starve = (age >= MAX_WAIT); this throttles issue so ALU bubbles appear.
- Ordering: FIFO is strictly in order; the ALU may overtake queued loads only to different rd (guaranteed by the scoreboard).

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 3 cycles, then high with no traffic.
  - Required: RegWrite=0, busy_vec=0, lsu_wb_ready=1.
- Load-use RAW:
  - Stimulus: issue lw x5 (accepted); next cycle issue add x6,x5,x1.
  - Required: issue_stall=1 until the LSU write of x5 commits (RegWrite=1, rd=5); the stall drops the cycle after the commit; busy_vec[5] returns to 0.
- Collision:
  - Stimulus: alu_wb_valid (rd=7, 0x11) and lsu_wb_valid (rd=9, 0xAB) in the same cycle.
  - Required: next cycle RegWrite=1, rd=7, ALUout=0x11; the following cycle rd=9, ALUout=0xAB.
- FIFO full:
  - Stimulus: ALU valid every cycle with two LSU pushes.
  - Required: lsu_wb_ready=0; a third LSU valid is held; once MAX_WAIT=4 waiting cycles elapse, issue_stall=1.
- x0 handling:
  - Stimulus: ALU writeback to rd=0, then issue lw x0.
  - Required: RegWrite stays 0 and busy_vec stays 0.
- Reset mid-operation:
  - Stimulus: 2 entries queued and busy[3]=1, then assert rst_n.
  - Required: FIFO empty, busy_vec=0, RegWrite=0 immediately (asynchronously).

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - issue, writeback and regfile-port bundle for regfile_wb_arbiter
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5
);
    logic                         issue_valid;
    logic [REG_DATA_WIDTH-1:0]    issue_rs1;
    logic [REG_DATA_WIDTH-1:0]    issue_rs2;
    logic [REG_DATA_WIDTH-1:0]    issue_rd;
    logic                         issue_is_load;
    logic                         issue_stall;

    logic                         alu_wb_valid;
    logic [REG_DATA_WIDTH-1:0]    alu_wb_rd;
    logic [DATA_WIDTH-1:0]        alu_wb_data;

    logic                         lsu_wb_valid;
    logic [REG_DATA_WIDTH-1:0]    lsu_wb_rd;
    logic [DATA_WIDTH-1:0]        lsu_wb_data;
    logic                         lsu_wb_ready;

    logic                         RegWrite;
    logic [REG_DATA_WIDTH-1:0]    rd;
    logic [DATA_WIDTH-1:0]        ALUout;
    logic [2**REG_DATA_WIDTH-1:0] busy_vec;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_load,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  issue_stall, lsu_wb_ready, RegWrite, rd, ALUout, busy_vec
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_is_load,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output issue_stall, lsu_wb_ready, RegWrite, rd, ALUout, busy_vec
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the regfile write port between ALU and LSU with a load scoreboard
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5,
    parameter int FIFO_DEPTH     = 2,
    parameter int MAX_WAIT       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NUM_REGS = 2**REG_DATA_WIDTH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int AGE_W    = $clog2(MAX_WAIT + 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [AGE_W-1:0] AGE_LIMIT  = AGE_W'(MAX_WAIT);

    logic [REG_DATA_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W:0]            count;
    logic [AGE_W-1:0]          age;

    logic                      wr_en;
    logic [REG_DATA_WIDTH-1:0] wr_rd;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      out_from_fifo;

    logic [NUM_REGS-1:0]       busy;
    logic [NUM_REGS-1:0]       busy_next;

    logic push;
    logic pop;
    logic starve;
    logic issue_accept;

    assign starve           = (age >= AGE_LIMIT);
    assign bus.issue_stall  = bus.issue_valid &&
                              (busy[bus.issue_rs1] || busy[bus.issue_rs2] ||
                               busy[bus.issue_rd] || starve);
    assign issue_accept     = bus.issue_valid && !bus.issue_stall;
    assign bus.lsu_wb_ready = (count != FULL_COUNT);

    assign push = bus.lsu_wb_valid && bus.lsu_wb_ready;
    assign pop  = !bus.alu_wb_valid && (count != '0);

    assign bus.RegWrite = wr_en;
    assign bus.rd       = wr_rd;
    assign bus.ALUout   = wr_data;
    assign bus.busy_vec = busy;

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.lsu_wb_rd;
            fifo_data[wr_ptr] <= bus.lsu_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if ((count == '0) || pop) begin
            age <= '0;
        end else if (!starve) begin
            age <= age + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en         <= 1'b0;
            wr_rd         <= '0;
            wr_data       <= '0;
            out_from_fifo <= 1'b0;
        end else if (bus.alu_wb_valid) begin
            wr_en         <= (bus.alu_wb_rd != '0);
            wr_rd         <= bus.alu_wb_rd;
            wr_data       <= bus.alu_wb_data;
            out_from_fifo <= 1'b0;
        end else if (pop) begin
            wr_en         <= (fifo_rd[rd_ptr] != '0);
            wr_rd         <= fifo_rd[rd_ptr];
            wr_data       <= fifo_data[rd_ptr];
            out_from_fifo <= 1'b1;
        end else begin
            wr_en         <= 1'b0;
            out_from_fifo <= 1'b0;
        end
    end

    // Clear lands after the commit cycle so a dependent issue never sees stale data; set wins.
    always_comb begin
        busy_next = busy;
        if (wr_en && out_from_fifo) begin
            busy_next[wr_rd] = 1'b0;
        end
        if (issue_accept && bus.issue_is_load && (bus.issue_rd != '0)) begin
            busy_next[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end
endmodule
